pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/ctrl_hold_timer.sv | 37 +++
 rtl/pipe_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Core-wide pipeline-control definitions: control FSM states and shared constants.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HOLD     = 2'd2
  } ctrl_state_e;

  localparam int unsigned HCNT_W = 8;
  localparam int unsigned RCNT_W = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/ctrl_hold_timer.sv
// Saturating hold-cycle counter with clear and timeout compare for pipe_ctrl.
module ctrl_hold_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [HCNT_W-1:0] LIMIT = HCNT_W'(HOLD_TIMEOUT - 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    if (clr) begin
      hcnt_d = '0;
    end else if (en && (hcnt_q != '1)) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end

  assign timeout = en && (hcnt_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: PC redirect, IF/ID and ID/EX stall/flush,
// multi-cycle hold with deferred redirect and hold timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 255,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en2ctrl,
  input  logic [ADDR_W-1:0] jump_addr2ctrl,
  input  logic              hold2ctrl,
  input  logic              hold_done,
  input  logic              load_use,
  output logic              jump_en2pc,
  output logic [ADDR_W-1:0] jump_addr2pc,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              stall_id_ex,
  output logic              flush_id_ex,
  output logic              hold_err,
  output logic              busy
);

  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(FLUSH_CYCLES - 1);
  localparam bit                MULTI_FLUSH = (FLUSH_CYCLES > 1);

  ctrl_state_e       state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              hold_active;
  logic              hold_timeout;
  logic              jump_go;
  logic [ADDR_W-1:0] jump_tgt;
  logic              hold_exit;

  assign hold_active = (state_q == ST_HOLD);

  ctrl_hold_timer #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!hold_active),
    .en     (hold_active),
    .timeout(hold_timeout)
  );

  always_comb begin
    state_d      = state_q;
    rcnt_d       = rcnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    jump_go      = 1'b0;
    jump_tgt     = '0;
    hold_exit    = 1'b0;
    jump_en2pc   = 1'b0;
    jump_addr2pc = '0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    hold_err     = 1'b0;
    busy         = (state_q != ST_RUN);

    unique case (state_q)
      ST_RUN, ST_REDIRECT: begin
        if (state_q == ST_REDIRECT) begin
          flush_if_id = 1'b1;
          rcnt_d      = rcnt_q - RCNT_W'(1);
          if (rcnt_q <= RCNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        // A hold wins over a redirect flush so IF/ID is never stalled and flushed together.
        if (hold2ctrl) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          flush_if_id = 1'b0;
          state_d     = ST_HOLD;
          if (jump_en2ctrl) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = jump_addr2ctrl;
          end
        end else if (jump_en2ctrl) begin
          jump_go  = 1'b1;
          jump_tgt = jump_addr2ctrl;
        end else if (load_use && (state_q == ST_RUN)) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      ST_HOLD: begin
        hold_exit = hold_done || hold_timeout;
        hold_err  = hold_timeout && !hold_done;
        if (!hold_exit) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
        end else begin
          state_d = ST_RUN;
          if (pend_valid_q) begin
            pend_valid_d = 1'b0;
            jump_go      = 1'b1;
            jump_tgt     = pend_addr_q;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (jump_go) begin
      jump_en2pc   = 1'b1;
      jump_addr2pc = jump_tgt;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      if (MULTI_FLUSH) begin
        state_d = ST_REDIRECT;
        rcnt_d  = RCNT_RELOAD;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (!rst_n) begin
      jump_en2pc   = 1'b0;
      jump_addr2pc = '0;
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      flush_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      flush_id_ex  = 1'b0;
      hold_err     = 1'b0;
      busy         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rcnt_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance A uses FLUSH_CYCLES=2/HOLD_TIMEOUT=255,
// instance B uses FLUSH_CYCLES=1/HOLD_TIMEOUT=4; both share the same stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en2ctrl;
  logic [31:0] jump_addr2ctrl;
  logic        hold2ctrl;
  logic        hold_done;
  logic        load_use;

  logic        a_jump_en2pc, a_stall_pc, a_stall_if_id, a_flush_if_id;
  logic        a_stall_id_ex, a_flush_id_ex, a_hold_err, a_busy;
  logic [31:0] a_jump_addr2pc;
  logic        b_jump_en2pc, b_stall_pc, b_stall_if_id, b_flush_if_id;
  logic        b_stall_id_ex, b_flush_id_ex, b_hold_err, b_busy;
  logic [31:0] b_jump_addr2pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FLUSH_CYCLES(2),
    .HOLD_TIMEOUT(255),
    .ADDR_W      (32)
  ) u_dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_en2ctrl  (jump_en2ctrl),
    .jump_addr2ctrl(jump_addr2ctrl),
    .hold2ctrl     (hold2ctrl),
    .hold_done     (hold_done),
    .load_use      (load_use),
    .jump_en2pc    (a_jump_en2pc),
    .jump_addr2pc  (a_jump_addr2pc),
    .stall_pc      (a_stall_pc),
    .stall_if_id   (a_stall_if_id),
    .flush_if_id   (a_flush_if_id),
    .stall_id_ex   (a_stall_id_ex),
    .flush_id_ex   (a_flush_id_ex),
    .hold_err      (a_hold_err),
    .busy          (a_busy)
  );

  pipe_ctrl #(
    .FLUSH_CYCLES(1),
    .HOLD_TIMEOUT(4),
    .ADDR_W      (32)
  ) u_dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_en2ctrl  (jump_en2ctrl),
    .jump_addr2ctrl(jump_addr2ctrl),
    .hold2ctrl     (hold2ctrl),
    .hold_done     (hold_done),
    .load_use      (load_use),
    .jump_en2pc    (b_jump_en2pc),
    .jump_addr2pc  (b_jump_addr2pc),
    .stall_pc      (b_stall_pc),
    .stall_if_id   (b_stall_if_id),
    .flush_if_id   (b_flush_if_id),
    .stall_id_ex   (b_stall_id_ex),
    .flush_id_ex   (b_flush_id_ex),
    .hold_err      (b_hold_err),
    .busy          (b_busy)
  );

  // {jump_en2pc, stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, hold_err, busy}
  logic [7:0] a_ctl, b_ctl;
  assign a_ctl = {a_jump_en2pc, a_stall_pc, a_stall_if_id, a_flush_if_id,
                  a_stall_id_ex, a_flush_id_ex, a_hold_err, a_busy};
  assign b_ctl = {b_jump_en2pc, b_stall_pc, b_stall_if_id, b_flush_if_id,
                  b_stall_id_ex, b_flush_id_ex, b_hold_err, b_busy};

  localparam logic [7:0] C_IDLE    = 8'b0000_0000;
  localparam logic [7:0] C_JUMP    = 8'b1001_0100;
  localparam logic [7:0] C_JUMP_B  = 8'b1001_0101;
  localparam logic [7:0] C_JUMP_TO = 8'b1001_0111;
  localparam logic [7:0] C_REDIR   = 8'b0001_0001;
  localparam logic [7:0] C_HSTART  = 8'b0110_1000;
  localparam logic [7:0] C_HOLD    = 8'b0110_1001;
  localparam logic [7:0] C_HEXIT   = 8'b0000_0001;
  localparam logic [7:0] C_HTO     = 8'b0000_0011;
  localparam logic [7:0] C_LDUSE   = 8'b0110_0100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the inputs already driven: sample mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [7:0] ea, input logic [31:0] eaa,
                     input bit chk_b, input logic [7:0] eb, input logic [31:0] eba);
    @(negedge clk);
    check_eq({tag, "/a_ctl"}, {24'h0, a_ctl}, {24'h0, ea});
    check_eq({tag, "/a_addr"}, a_jump_addr2pc, eaa);
    if (chk_b) begin
      check_eq({tag, "/b_ctl"}, {24'h0, b_ctl}, {24'h0, eb});
      check_eq({tag, "/b_addr"}, b_jump_addr2pc, eba);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit j, input logic [31:0] ja, input bit h, input bit hd, input bit lu);
    jump_en2ctrl   = j;
    jump_addr2ctrl = ja;
    hold2ctrl      = h;
    hold_done      = hd;
    load_use       = lu;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 32'h40, 0, 0, 0);

    // Reset held for three cycles with a jump request present
    for (int i = 0; i < 3; i++) cyc("rst", C_IDLE, 0, 1, C_IDLE, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    cyc("rst_rel", C_IDLE, 0, 1, C_IDLE, 0);

    // Plain jump
    drive(1, 32'h40, 0, 0, 0);
    cyc("jmp0", C_JUMP, 32'h40, 1, C_JUMP, 32'h40);
    drive(0, 0, 0, 0, 0);
    cyc("jmp1", C_REDIR, 0, 1, C_IDLE, 0);
    cyc("jmp2", C_IDLE, 0, 1, C_IDLE, 0);

    // Hold, done on cycle 5; B times out on its 4th HOLD cycle
    drive(0, 0, 1, 0, 0);
    cyc("hold0", C_HSTART, 0, 1, C_HSTART, 0);
    drive(0, 0, 0, 0, 0);
    cyc("hold1", C_HOLD, 0, 1, C_HOLD, 0);
    cyc("hold2", C_HOLD, 0, 0, C_IDLE, 0);
    cyc("hold3", C_HOLD, 0, 1, C_HOLD, 0);
    cyc("hold4", C_HOLD, 0, 1, C_HTO, 0);
    drive(0, 0, 0, 1, 0);
    cyc("hold5", C_HEXIT, 0, 1, C_IDLE, 0);
    drive(0, 0, 0, 0, 0);
    cyc("hold6", C_IDLE, 0, 1, C_IDLE, 0);

    // Jump+hold deferred; jumps during HOLD ignored
    drive(1, 32'h100, 1, 0, 0);
    cyc("jh0", C_HSTART, 0, 1, C_HSTART, 0);
    drive(1, 32'h200, 0, 0, 0);
    cyc("jh1", C_HOLD, 0, 1, C_HOLD, 0);
    drive(0, 0, 0, 0, 0);
    cyc("jh2", C_HOLD, 0, 1, C_HOLD, 0);
    drive(0, 0, 0, 1, 0);
    cyc("jh3", C_JUMP_B, 32'h100, 1, C_JUMP_B, 32'h100);
    drive(0, 0, 0, 0, 0);
    cyc("jh4", C_REDIR, 0, 1, C_IDLE, 0);
    cyc("jh5", C_IDLE, 0, 1, C_IDLE, 0);

    // Timeout on B with a pending jump still applied
    drive(1, 32'h300, 1, 0, 0);
    cyc("to0", C_HSTART, 0, 1, C_HSTART, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) cyc("to_h", C_HOLD, 0, 1, C_HOLD, 0);
    cyc("to4", C_HOLD, 0, 1, C_JUMP_TO, 32'h300);
    drive(0, 0, 0, 1, 0);
    cyc("to5", C_JUMP_B, 32'h300, 1, C_IDLE, 0);
    drive(0, 0, 0, 0, 0);
    cyc("to6", C_REDIR, 0, 1, C_IDLE, 0);
    cyc("to7", C_IDLE, 0, 1, C_IDLE, 0);

    // hold_done coincides with B's timeout: normal exit, no hold_err
    drive(0, 0, 1, 0, 0);
    cyc("hdt0", C_HSTART, 0, 1, C_HSTART, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) cyc("hdt_h", C_HOLD, 0, 1, C_HOLD, 0);
    drive(0, 0, 0, 1, 0);
    cyc("hdt4", C_HEXIT, 0, 1, C_HEXIT, 0);
    drive(0, 0, 0, 0, 0);
    cyc("hdt5", C_IDLE, 0, 1, C_IDLE, 0);

    // load_use alone, then with a jump, then during REDIRECT
    drive(0, 0, 0, 0, 1);
    cyc("lu0", C_LDUSE, 0, 1, C_LDUSE, 0);
    drive(0, 0, 0, 0, 0);
    cyc("lu1", C_IDLE, 0, 1, C_IDLE, 0);
    drive(1, 32'h80, 0, 0, 1);
    cyc("luj0", C_JUMP, 32'h80, 1, C_JUMP, 32'h80);
    drive(0, 0, 0, 0, 1);
    cyc("luj1", C_REDIR, 0, 1, C_LDUSE, 0);
    drive(0, 0, 0, 0, 0);
    cyc("luj2", C_IDLE, 0, 1, C_IDLE, 0);

    // New jump while in REDIRECT reloads the flush window
    drive(1, 32'h40, 0, 0, 0);
    cyc("rj0", C_JUMP, 32'h40, 1, C_JUMP, 32'h40);
    drive(1, 32'h44, 0, 0, 0);
    cyc("rj1", C_JUMP_B, 32'h44, 1, C_JUMP, 32'h44);
    drive(0, 0, 0, 0, 0);
    cyc("rj2", C_REDIR, 0, 1, C_IDLE, 0);
    cyc("rj3", C_IDLE, 0, 1, C_IDLE, 0);

    // Hold arriving in REDIRECT takes over; no flush alongside the stall
    drive(1, 32'h40, 0, 0, 0);
    cyc("rh0", C_JUMP, 32'h40, 1, C_JUMP, 32'h40);
    drive(0, 0, 1, 0, 0);
    cyc("rh1", C_HOLD, 0, 1, C_HSTART, 0);
    drive(0, 0, 0, 0, 0);
    cyc("rh2", C_HOLD, 0, 1, C_HOLD, 0);
    drive(0, 0, 0, 1, 0);
    cyc("rh3", C_HEXIT, 0, 1, C_HEXIT, 0);
    drive(0, 0, 0, 0, 0);
    cyc("rh4", C_IDLE, 0, 1, C_IDLE, 0);

    // Reset mid-HOLD drops the pending jump
    drive(1, 32'h500, 1, 0, 0);
    cyc("rsh0", C_HSTART, 0, 1, C_HSTART, 0);
    drive(0, 0, 0, 0, 0);
    cyc("rsh1", C_HOLD, 0, 1, C_HOLD, 0);
    rst_n = 1'b0;
    cyc("rsh2", C_IDLE, 0, 1, C_IDLE, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0);
    cyc("rsh3", C_IDLE, 0, 1, C_IDLE, 0);
    drive(0, 0, 0, 0, 0);
    cyc("rsh4", C_IDLE, 0, 1, C_IDLE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
